aclk_timegen: RTL and testbench

- Upstream time-base generator for the alarm clock; feeds `one_second` to the alarm-clock controller and `one_minute` to the clock counter.
- Divides the system clock into single-cycle second and minute strobes.
- Takes `reset_count` back from the controller to re-align the time base whenever new time is loaded.
- `fast_watch` mode turns every second strobe into a minute strobe, for demo and test use.

---
 rtl/aclk_timegen.sv | 99 +++++++++
 tb/tb_aclk_timegen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/aclk_timegen.sv
// ----------------------------------------------------------------------------
// aclk_timegen
// Time-base generator for the alarm clock. It divides clk into one-cycle
// second strobes, and counts those into one-cycle minute strobes.
//
// Optional feature macro: ACLK_TIMEGEN_PAUSE_EN
//   When defined, the `pause` input is added. While `pause` is high the
//   prescaler and the seconds counter hold, and both strobes stay low.
//   When undefined, the block behaves as if `pause` were tied to 0.
//
// Ports:
//   clk          system clock; all state changes on its rising edge
//   reset        asynchronous active-low reset, clears all state
//   reset_count  synchronous, level-sensitive clear of the time base
//   fast_watch   when 1, one_minute pulses on every second strobe
//   pause        (ACLK_TIMEGEN_PAUSE_EN only) freezes counting
//   one_second   registered one-cycle second strobe
//   one_minute   registered one-cycle minute strobe
//   sec_count    registered seconds value, 0 .. SEC_PER_MIN-1
// ----------------------------------------------------------------------------
module aclk_timegen #(
    parameter int CLK_PER_SEC = 256,
    parameter int SEC_PER_MIN = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reset_count,
    input  logic       fast_watch,
`ifdef ACLK_TIMEGEN_PAUSE_EN
    input  logic       pause,
`endif
    output logic       one_second,
    output logic       one_minute,
    output logic [5:0] sec_count
);

    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);
    localparam logic [5:0]    SEC_MAX   = 6'(SEC_PER_MIN - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic          one_second_q, one_second_d;
    logic          one_minute_q, one_minute_d;
    logic          run;

`ifdef ACLK_TIMEGEN_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    // reset_count wins over a coincident terminal count: that strobe is
    // dropped, not deferred. pause only holds; it never clears.
    always_comb begin
        presc_d      = presc_q;
        sec_d        = sec_q;
        one_second_d = 1'b0;
        one_minute_d = 1'b0;
        if (reset_count) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (run) begin
            if (presc_q == PRESC_MAX) begin
                presc_d      = '0;
                one_second_d = 1'b1;
                // The seconds counter wraps the same way in both modes;
                // fast_watch only decides which ticks become minute strobes.
                if (sec_q == SEC_MAX) begin
                    sec_d = '0;
                end else begin
                    sec_d = sec_q + 6'd1;
                end
                one_minute_d = fast_watch | (sec_q == SEC_MAX);
            end else begin
                presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q      <= '0;
            sec_q        <= '0;
            one_second_q <= 1'b0;
            one_minute_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            one_second_q <= one_second_d;
            one_minute_q <= one_minute_d;
        end
    end

    assign one_second = one_second_q;
    assign one_minute = one_minute_q;
    assign sec_count  = sec_q;

endmodule

// File: tb/tb_aclk_timegen.sv
module tb_aclk_timegen;

    localparam int C = 4;
    localparam int S = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       reset_count = 1'b0;
    logic       fast_watch = 1'b0;
    logic       pause_tb = 1'b0;
    logic       one_second;
    logic       one_minute;
    logic [5:0] sec_count;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    aclk_timegen #(.CLK_PER_SEC(C), .SEC_PER_MIN(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .reset_count (reset_count),
        .fast_watch  (fast_watch),
`ifdef ACLK_TIMEGEN_PAUSE_EN
        .pause       (pause_tb),
`endif
        .one_second  (one_second),
        .one_minute  (one_minute),
        .sec_count   (sec_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: n counts enabled edges since the last alignment.
    // A second strobe follows every C-th such edge; the seconds value is
    // the number of whole seconds elapsed, modulo S.
    int   n = 0;
    logic m_os = 1'b0;
    logic m_om = 1'b0;
    int   m_sec = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n = 0; m_os = 1'b0; m_om = 1'b0; m_sec = 0;
        end else if (reset_count) begin
            n = 0; m_os = 1'b0; m_om = 1'b0; m_sec = 0;
        end else if (pause_tb) begin
            m_os = 1'b0; m_om = 1'b0;
        end else begin
            n = n + 1;
            m_os  = ((n % C) == 0);
            m_sec = (n / C) % S;
            m_om  = m_os && (fast_watch || (m_sec == 0));
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_one_second", int'(one_second), int'(m_os));
            chk("cyc_one_minute", int'(one_minute), int'(m_om));
            chk("cyc_sec_count",  int'(sec_count),  m_sec);
            chk("cyc_min_implies_sec", int'(one_minute && !one_second), 0);
        end
    end

    // Advance k rising edges, then settle 2 time units past the edge.
    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        reset_count = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        // Test 1: reset timing
        do_reset();
        chk_en = 1'b1;
        chk("rst_one_second", int'(one_second), 0);
        chk("rst_sec_count",  int'(sec_count), 0);
        step(3);
        chk("t1_e3_os", int'(one_second), 0);
        step(1);
        chk("t1_e4_os",  int'(one_second), 1);
        chk("t1_e4_sec", int'(sec_count), 1);
        chk("t1_e4_om",  int'(one_minute), 0);
        step(1);
        chk("t1_e5_os", int'(one_second), 0);
        step(3);
        chk("t1_e8_os",  int'(one_second), 1);
        chk("t1_e8_sec", int'(sec_count), 2);
        step(4);
        chk("t1_e12_om",  int'(one_minute), 1);
        chk("t1_e12_sec", int'(sec_count), 0);

        // Test 2: wrap check out to edge 40
        step(12);
        chk("t2_e24_om", int'(one_minute), 1);
        step(11);
        chk("t2_e35_om", int'(one_minute), 0);
        step(1);
        chk("t2_e36_om", int'(one_minute), 1);
        step(4);

        // Test 3: fast mode, then back to normal after edge 13
        fast_watch = 1'b1;
        do_reset();
        step(4);
        chk("t3_e4_om", int'(one_minute), 1);
        step(4);
        chk("t3_e8_om", int'(one_minute), 1);
        step(4);
        chk("t3_e12_om", int'(one_minute), 1);
        step(1);
        fast_watch = 1'b0;
        step(3);
        chk("t3_e16_os", int'(one_second), 1);
        chk("t3_e16_om", int'(one_minute), 0);
        step(8);
        chk("t3_e24_om", int'(one_minute), 1);

        // Test 4: reset_count on a terminal edge
        do_reset();
        step(3);
        reset_count = 1'b1;
        step(1);
        reset_count = 1'b0;
        chk("t4_e4_os",  int'(one_second), 0);
        chk("t4_e4_sec", int'(sec_count), 0);
        step(3);
        chk("t4_e7_os", int'(one_second), 0);
        step(1);
        chk("t4_e8_os",  int'(one_second), 1);
        chk("t4_e8_sec", int'(sec_count), 1);

        // Test 5: asynchronous reset mid-operation (after edge 4's strobe)
        do_reset();
        step(4);
        reset = 1'b0;
        #1;
        chk("t5_async_os",  int'(one_second), 0);
        chk("t5_async_sec", int'(sec_count), 0);
        step(3);
        reset = 1'b1;
        step(3);
        chk("t5_r3_os", int'(one_second), 0);
        step(1);
        chk("t5_r4_os",  int'(one_second), 1);
        chk("t5_r4_sec", int'(sec_count), 1);

`ifdef ACLK_TIMEGEN_PAUSE_EN
        // Test 6: pause sampled high on edges 2..6 delays the strobe to edge 9
        do_reset();
        step(1);
        pause_tb = 1'b1;
        step(5);
        chk("t6_paused_sec", int'(sec_count), 0);
        chk("t6_paused_os",  int'(one_second), 0);
        pause_tb = 1'b0;
        step(2);
        chk("t6_e8_os", int'(one_second), 0);
        step(1);
        chk("t6_e9_os",  int'(one_second), 1);
        chk("t6_e9_sec", int'(sec_count), 1);
`endif

        step(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
